// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: default widths, FSM states and
// the link-register address that jr/jal depend on.
package hazard_ctrl_pkg;

    localparam int HC_AWIDTH    = 5;
    localparam int HC_CNT_WIDTH = 16;

    // Scoreboard entries carry {valid, is_load} on top of the destination address.
    localparam int SB_TAG_BITS = 2;

    localparam logic [4:0] RA_REG = 5'd31;

    typedef enum logic [1:0] {
        HC_RUN     = 2'd0,
        HC_LDSTALL = 2'd1,
        HC_JRWAIT  = 2'd2
    } hc_state_e;

endpackage

// File: rtl/hc_scoreboard.sv
// Two-entry destination scoreboard shadowing the EX and MEM stages, with
// address match outputs for the ID-stage sources and the link register.
module hc_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int AWIDTH = HC_AWIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_hold,
    input  logic              i_bubble,
    input  logic              i_id_valid,
    input  logic              i_id_load,
    input  logic [AWIDTH-1:0] i_id_dst,
    input  logic [AWIDTH-1:0] i_rs,
    input  logic [AWIDTH-1:0] i_rt,
    output logic              o_rs_match,
    output logic              o_rt_match,
    output logic              o_ex_load,
    output logic              o_ra_match
);
    localparam int                EW = AWIDTH + SB_TAG_BITS;
    localparam logic [AWIDTH-1:0] RA = AWIDTH'(RA_REG);

    logic [EW-1:0]   r_ex;
    // A load that has reached MEM is forwardable, so only valid+dst are kept.
    logic [AWIDTH:0] r_mem;

    logic              w_ex_valid;
    logic [AWIDTH-1:0] w_ex_dst;
    logic              w_mem_valid;
    logic [AWIDTH-1:0] w_mem_dst;

    assign w_ex_valid  = r_ex[EW-1];
    assign o_ex_load   = r_ex[EW-1] & r_ex[AWIDTH];
    assign w_ex_dst    = r_ex[AWIDTH-1:0];
    assign w_mem_valid = r_mem[AWIDTH];
    assign w_mem_dst   = r_mem[AWIDTH-1:0];

    // NOTE: the entries are pipeline state, not a storage array, so they are reset;
    // a stale valid bit after reset would stall the first instructions.
    // NOTE: sequential state uses non-blocking assignments so r_mem captures the
    // pre-edge r_ex rather than the value written in this same block.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
        end else if (!i_hold) begin
            r_mem <= {w_ex_valid, w_ex_dst};
            r_ex  <= i_bubble ? '0 : {i_id_valid, i_id_load, i_id_dst};
        end
    end

    assign o_rs_match = w_ex_valid & (i_rs != '0) & (i_rs == w_ex_dst);
    assign o_rt_match = w_ex_valid & (i_rt != '0) & (i_rt == w_ex_dst);
    assign o_ra_match = (w_ex_valid & (w_ex_dst == RA)) | (w_mem_valid & (w_mem_dst == RA));

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage pipeline scheduler: stalls, bubbles and flushes for load-use, jr/jal,
// taken branches and data-memory wait, plus a saturating stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int AWIDTH    = HC_AWIDTH,
    parameter int CNT_WIDTH = HC_CNT_WIDTH
) (
    input  logic                 hc_i_clk,
    input  logic                 hc_i_rst,
    input  logic                 hc_i_ce,
    input  logic [AWIDTH-1:0]    hc_i_addr_rs,
    input  logic [AWIDTH-1:0]    hc_i_addr_rt,
    input  logic [AWIDTH-1:0]    hc_i_addr_rd,
    input  logic                 hc_i_reg_wr,
    input  logic                 hc_i_reg_dst,
    input  logic                 hc_i_memtoreg,
    input  logic                 hc_i_alu_src,
    input  logic                 hc_i_memwrite,
    input  logic                 hc_i_branch,
    input  logic                 hc_i_jr,
    input  logic                 hc_i_jal,
    input  logic                 hc_i_ex_taken,
    input  logic                 hc_i_mem_busy,
    output logic                 hc_o_pc_stall,
    output logic                 hc_o_ifid_stall,
    output logic                 hc_o_ifid_flush,
    output logic                 hc_o_idex_bubble,
    output logic                 hc_o_jr_go,
    output logic                 hc_o_jal_go,
    output logic [CNT_WIDTH-1:0] hc_o_stall_cnt
);
    localparam logic [AWIDTH-1:0] RA = AWIDTH'(RA_REG);

    hc_state_e r_state;
    hc_state_e w_next_state;

    logic              w_rs_used;
    logic              w_rt_used;
    logic [AWIDTH-1:0] w_dst;
    logic              w_id_valid;
    logic              w_rs_match;
    logic              w_rt_match;
    logic              w_ex_load;
    logic              w_ra_match;
    logic              w_load_use;
    logic              w_jr_haz;
    logic              w_count;

    logic [CNT_WIDTH-1:0] r_stall_cnt;

    // jal reads no sources; rt is a source for branches, stores and R-type ops.
    assign w_rs_used  = hc_i_ce & ~hc_i_jal;
    assign w_rt_used  = hc_i_ce & ~hc_i_jal & (hc_i_branch | hc_i_memwrite | ~hc_i_alu_src);
    assign w_dst      = hc_i_jal ? RA : (hc_i_reg_dst ? hc_i_addr_rd : hc_i_addr_rt);
    assign w_id_valid = hc_i_ce & hc_i_reg_wr & (w_dst != '0);

    hc_scoreboard #(
        .AWIDTH (AWIDTH)
    ) u_scoreboard (
        .i_clk      (hc_i_clk),
        .i_rst_n    (hc_i_rst),
        .i_hold     (hc_i_mem_busy),
        .i_bubble   (hc_o_idex_bubble),
        .i_id_valid (w_id_valid),
        .i_id_load  (hc_i_memtoreg),
        .i_id_dst   (w_dst),
        .i_rs       (hc_i_addr_rs),
        .i_rt       (hc_i_addr_rt),
        .o_rs_match (w_rs_match),
        .o_rt_match (w_rt_match),
        .o_ex_load  (w_ex_load),
        .o_ra_match (w_ra_match)
    );

    assign w_load_use = w_ex_load & ((w_rs_used & w_rs_match) | (w_rt_used & w_rt_match));
    assign w_jr_haz   = hc_i_ce & hc_i_jr & w_ra_match;

    always_ff @(posedge hc_i_clk or negedge hc_i_rst) begin
        if (!hc_i_rst) r_state <= HC_RUN;
        else           r_state <= w_next_state;
    end

    // NOTE: every output and the next state get a default first, so no path
    // through the priority chain can leave a value unassigned and infer a latch.
    always_comb begin
        w_next_state     = HC_RUN;
        hc_o_pc_stall    = 1'b0;
        hc_o_ifid_stall  = 1'b0;
        hc_o_ifid_flush  = 1'b0;
        hc_o_idex_bubble = 1'b0;
        hc_o_jr_go       = 1'b0;
        hc_o_jal_go      = 1'b0;
        if (hc_i_mem_busy) begin
            w_next_state    = r_state;
            hc_o_pc_stall   = 1'b1;
            hc_o_ifid_stall = 1'b1;
        end else if (hc_i_ex_taken) begin
            hc_o_ifid_flush  = 1'b1;
            hc_o_idex_bubble = 1'b1;
        end else if (w_jr_haz) begin
            w_next_state     = HC_JRWAIT;
            hc_o_pc_stall    = 1'b1;
            hc_o_ifid_stall  = 1'b1;
            hc_o_idex_bubble = 1'b1;
        end else if (w_load_use) begin
            w_next_state     = HC_LDSTALL;
            hc_o_pc_stall    = 1'b1;
            hc_o_ifid_stall  = 1'b1;
            hc_o_idex_bubble = 1'b1;
        end else if (hc_i_ce & hc_i_jr) begin
            hc_o_jr_go      = 1'b1;
            hc_o_ifid_flush = 1'b1;
        end else if (hc_i_ce & hc_i_jal) begin
            hc_o_jal_go     = 1'b1;
            hc_o_ifid_flush = 1'b1;
        end
    end

    // Bubbles from a taken branch are not hazard stalls; mem_busy never bubbles.
    assign w_count = hc_o_idex_bubble & ~hc_i_ex_taken;

    always_ff @(posedge hc_i_clk or negedge hc_i_rst) begin
        if (!hc_i_rst)
            r_stall_cnt <= '0;
        else if (w_count && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign hc_o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl; a queue-based pipeline model
// predicts each cycle's controls and a negedge monitor compares them.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce, reg_wr, reg_dst, memtoreg, alu_src, memwrite, branch, jr, jal;
    logic        ex_taken, mem_busy;
    logic [4:0]  rs, rt, rd;
    logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, jr_go, jal_go;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .hc_i_clk         (clk),
        .hc_i_rst         (rst_n),
        .hc_i_ce          (ce),
        .hc_i_addr_rs     (rs),
        .hc_i_addr_rt     (rt),
        .hc_i_addr_rd     (rd),
        .hc_i_reg_wr      (reg_wr),
        .hc_i_reg_dst     (reg_dst),
        .hc_i_memtoreg    (memtoreg),
        .hc_i_alu_src     (alu_src),
        .hc_i_memwrite    (memwrite),
        .hc_i_branch      (branch),
        .hc_i_jr          (jr),
        .hc_i_jal         (jal),
        .hc_i_ex_taken    (ex_taken),
        .hc_i_mem_busy    (mem_busy),
        .hc_o_pc_stall    (pc_stall),
        .hc_o_ifid_stall  (ifid_stall),
        .hc_o_ifid_flush  (ifid_flush),
        .hc_o_idex_bubble (idex_bubble),
        .hc_o_jr_go       (jr_go),
        .hc_o_jal_go      (jal_go),
        .hc_o_stall_cnt   (stall_cnt)
    );

    typedef struct {
        bit       ce;
        bit [4:0] rs, rt, rd;
        bit       reg_wr, reg_dst, memtoreg, alu_src, memwrite, branch, jr, jal;
    } instr_t;

    typedef struct {
        bit       valid;
        bit       is_load;
        bit [4:0] dst;
    } ent_t;

    typedef struct {
        bit pc_stall, ifid_stall, ifid_flush, bubble, jr_go, jal_go;
        int cnt;
    } exp_t;

    typedef enum {K_FREEZE, K_KILL, K_STALL, K_ISSUE} kind_e;

    ent_t pipe[$];     // [0] = instruction in EX, [1] = instruction in MEM
    int   m_cnt;
    exp_t exp_q[$];
    exp_t smp;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    function automatic int pack_ctl(exp_t e);
        return {26'd0, e.pc_stall, e.ifid_stall, e.ifid_flush, e.bubble, e.jr_go, e.jal_go};
    endfunction

    // ---------------- instruction builders ----------------
    function automatic instr_t i_nop();
        instr_t i = '{default: 0};
        return i;
    endfunction
    function automatic instr_t i_lw(bit [4:0] dst, bit [4:0] base);
        instr_t i = i_nop();
        i.ce = 1; i.rs = base; i.rt = dst; i.reg_wr = 1; i.memtoreg = 1; i.alu_src = 1;
        return i;
    endfunction
    function automatic instr_t i_add(bit [4:0] d, bit [4:0] s, bit [4:0] t);
        instr_t i = i_nop();
        i.ce = 1; i.rs = s; i.rt = t; i.rd = d; i.reg_wr = 1; i.reg_dst = 1;
        return i;
    endfunction
    function automatic instr_t i_addi(bit [4:0] t, bit [4:0] s);
        instr_t i = i_nop();
        i.ce = 1; i.rs = s; i.rt = t; i.reg_wr = 1; i.alu_src = 1;
        return i;
    endfunction
    function automatic instr_t i_sw(bit [4:0] t, bit [4:0] base);
        instr_t i = i_nop();
        i.ce = 1; i.rs = base; i.rt = t; i.memwrite = 1; i.alu_src = 1;
        return i;
    endfunction
    function automatic instr_t i_beq(bit [4:0] s, bit [4:0] t);
        instr_t i = i_nop();
        i.ce = 1; i.rs = s; i.rt = t; i.branch = 1;
        return i;
    endfunction
    function automatic instr_t i_jr();
        instr_t i = i_nop();
        i.ce = 1; i.rs = 31; i.jr = 1;
        return i;
    endfunction
    function automatic instr_t i_jal();
        instr_t i = i_nop();
        i.ce = 1; i.rd = 31; i.reg_wr = 1; i.jal = 1;
        return i;
    endfunction

    function automatic bit [4:0] rreg();
        bit [4:0] r;
        case ($urandom_range(0, 3))
            0:       r = 5'd0;
            1:       r = 5'd8;
            2:       r = 5'd9;
            default: r = 5'd31;
        endcase
        return r;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        case ($urandom_range(0, 7))
            0:       i = i_nop();
            1:       i = i_lw(rreg(), rreg());
            2:       i = i_add(rreg(), rreg(), rreg());
            3:       i = i_addi(rreg(), rreg());
            4:       i = i_sw(rreg(), rreg());
            5:       i = i_beq(rreg(), rreg());
            6:       i = i_jr();
            default: i = i_jal();
        endcase
        return i;
    endfunction

    // ---------------- reference model ----------------
    function automatic kind_e predict(instr_t ins, bit taken, bit busy, output exp_t e);
        int srcs[$];
        bit lu = 0;
        bit jh = 0;
        e = '{default: 0};
        e.cnt = m_cnt;
        if (ins.ce && !ins.jal) begin
            srcs.push_back(int'(ins.rs));
            if (ins.branch || ins.memwrite || !ins.alu_src) srcs.push_back(int'(ins.rt));
        end
        foreach (srcs[k])
            if (srcs[k] != 0 && pipe[0].valid && pipe[0].is_load && int'(pipe[0].dst) == srcs[k]) lu = 1;
        if (ins.ce && ins.jr)
            foreach (pipe[k]) if (pipe[k].valid && pipe[k].dst == 5'd31) jh = 1;
        if (busy) begin
            e.pc_stall = 1; e.ifid_stall = 1;
            return K_FREEZE;
        end
        if (taken) begin
            e.ifid_flush = 1; e.bubble = 1;
            return K_KILL;
        end
        if (lu || jh) begin
            e.pc_stall = 1; e.ifid_stall = 1; e.bubble = 1;
            return K_STALL;
        end
        e.jr_go      = ins.ce && ins.jr;
        e.jal_go     = ins.ce && ins.jal && !ins.jr;
        e.ifid_flush = e.jr_go || e.jal_go;
        return K_ISSUE;
    endfunction

    task automatic advance(kind_e k, instr_t ins);
        ent_t n = '{default: 0};
        if (k == K_FREEZE) return;
        if (k == K_ISSUE) begin
            n.dst     = ins.jal ? 5'd31 : (ins.reg_dst ? ins.rd : ins.rt);
            n.valid   = ins.ce && ins.reg_wr && n.dst != 0;
            n.is_load = ins.memtoreg;
        end
        if (k == K_STALL && m_cnt < 65535) m_cnt++;
        pipe.push_front(n);
        void'(pipe.pop_back());
    endtask

    task automatic model_reset();
        ent_t z = '{default: 0};
        pipe  = {z, z};
        m_cnt = 0;
    endtask

    // ---------------- driver ----------------
    task automatic drive(instr_t i, bit taken, bit busy);
        ce = i.ce; rs = i.rs; rt = i.rt; rd = i.rd;
        reg_wr = i.reg_wr; reg_dst = i.reg_dst; memtoreg = i.memtoreg; alu_src = i.alu_src;
        memwrite = i.memwrite; branch = i.branch; jr = i.jr; jal = i.jal;
        ex_taken = taken; mem_busy = busy;
    endtask

    task automatic sample();
        smp.pc_stall   = pc_stall;
        smp.ifid_stall = ifid_stall;
        smp.ifid_flush = ifid_flush;
        smp.bubble     = idex_bubble;
        smp.jr_go      = jr_go;
        smp.jal_go     = jal_go;
        smp.cnt        = int'(stall_cnt);
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic step(instr_t ins, bit taken, bit busy, output kind_e k);
        exp_t e;
        drive(ins, taken, busy);
        k = predict(ins, taken, busy, e);
        exp_q.push_back(e);
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        advance(k, ins);
    endtask

    task automatic cyc(instr_t ins, bit taken = 0, bit busy = 0);
        kind_e k;
        step(ins, taken, busy, k);
    endtask

    task automatic do_reset();
        exp_t e = '{default: 0};
        drive(i_nop(), 0, 0);
        rst_n = 1'b0;
        model_reset();
        exp_q.push_back(e);
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a.pc_stall = pc_stall; a.ifid_stall = ifid_stall; a.ifid_flush = ifid_flush;
            a.bubble = idex_bubble; a.jr_go = jr_go; a.jal_go = jal_go; a.cnt = 0;
            check("ctl{pcst,ifst,flush,bub,jrgo,jalgo}", pack_ctl(a), pack_ctl(e));
            check("stall_cnt", int'(stall_cnt), e.cnt);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        instr_t cur;
        kind_e  k;
        bit     taken, busy;

        rst_n = 1'b0;
        drive(i_nop(), 0, 0);
        model_reset();
        @(posedge clk);
        #1;

        // Reset state: idle outputs and a zero counter.
        do_reset();
        check("reset_ctl", pack_ctl(smp), 0);
        check("reset_cnt", smp.cnt, 0);

        // lw $8 ; add $9,$8,$10 -> exactly one stall cycle.
        do_reset();
        cyc(i_lw(8, 0));
        cyc(i_add(9, 8, 10));
        check("ldu_stall", {smp.pc_stall, smp.ifid_stall, smp.bubble}, 3'b111);
        cyc(i_add(9, 8, 10));
        check("ldu_release", {smp.pc_stall, smp.bubble}, 2'b00);
        cyc(i_nop());
        check("ldu_cnt", smp.cnt, 1);

        // lw $8 ; nop ; add $9,$8,$1 -> no stall.
        do_reset();
        cyc(i_lw(8, 0));
        cyc(i_nop());
        cyc(i_add(9, 8, 1));
        check("ldu_gap_ctl", pack_ctl(smp), 0);
        cyc(i_nop());
        check("ldu_gap_cnt", smp.cnt, 0);

        // addi $31 ; jr -> two JRWAIT cycles then redirect.
        do_reset();
        cyc(i_addi(31, 0));
        cyc(i_jr());
        check("jr_wait1", {smp.pc_stall, smp.bubble, smp.jr_go}, 3'b110);
        cyc(i_jr());
        check("jr_wait2", {smp.pc_stall, smp.bubble, smp.jr_go}, 3'b110);
        cyc(i_jr());
        check("jr_go", {smp.jr_go, smp.ifid_flush, smp.pc_stall}, 3'b110);
        cyc(i_nop());
        check("jr_cnt", smp.cnt, 2);

        // Load-use in ID while a branch in EX resolves taken.
        do_reset();
        cyc(i_lw(8, 0));
        cyc(i_add(9, 8, 10), 1, 0);
        check("taken_ctl", {smp.ifid_flush, smp.bubble, smp.pc_stall, smp.ifid_stall}, 4'b1100);
        cyc(i_nop());
        check("taken_cnt", smp.cnt, 0);

        // mem_busy for three cycles while in LDSTALL.
        do_reset();
        cyc(i_lw(8, 0));
        cyc(i_add(9, 8, 10));
        for (int b = 0; b < 3; b++) begin
            cyc(i_add(9, 8, 10), 0, 1);
            check("busy_hold", {smp.pc_stall, smp.ifid_stall, smp.bubble}, 3'b110);
        end
        cyc(i_add(9, 8, 10));
        check("busy_release", {smp.pc_stall, smp.bubble}, 2'b00);
        cyc(i_nop());
        check("busy_cnt", smp.cnt, 1);

        // Reset during JRWAIT: the next jr redirects immediately.
        do_reset();
        cyc(i_addi(31, 0));
        cyc(i_jr());
        check("rst_jr_wait", smp.bubble, 1);
        do_reset();
        cyc(i_jr());
        check("rst_jr_go", {smp.jr_go, smp.ifid_flush}, 2'b11);
        check("rst_jr_cnt", smp.cnt, 0);

        // Randomized traffic with realistic IF/ID behaviour.
        do_reset();
        cur = i_nop();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                cur = i_nop();
            end
            taken = ($urandom_range(0, 11) == 0);
            busy  = ($urandom_range(0, 9) == 0);
            step(cur, taken, busy, k);
            if (k == K_FREEZE || k == K_STALL)
                cur = cur;
            else if (k == K_KILL || (cur.ce && (cur.jr || cur.jal)))
                cur = i_nop();
            else
                cur = rand_instr();
        end

        drive(i_nop(), 0, 0);
        for (int w = 0; w < 5 && exp_q.size() != 0; w++) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
